tape_in: RTL and testbench
==========================

Name: tape_in

Overview:
- Tape-input receiver; the input-side counterpart of the sound/tape-out path.
- Synchronises and deglitches the asynchronous EAR/tape-in pin.
- Presents a clean level for port #FE bit 6 reads.
- Measures the duration of every completed pulse into a small FIFO, so software can fetch pulse lengths instead of bit-banging.

Parameters:
- PRESC, 28, clocks per width tick (1 us at 28 MHz); must be >= 2.
- FILT_LEN, 4, consecutive differing samples required to accept a level change; must be >= 2.
- CNT_W, 16, width counter bits.
- DEPTH, 4, FIFO entries; must be a power of 2.

Ports:
- clk, in, 1: system clock, all logic on posedge.
- rst, in, 1: asynchronous, active-high reset.
- tapein, in, 1: raw asynchronous tape input pin.
- pop, in, 1: one-clock strobe that consumes the FIFO head.
- clr, in, 1: one-clock strobe that flushes the FIFO and clears the overflow flag.
- tape_bit, out, 1: filtered tape level.
- pulse_valid, out, 1: FIFO not empty.
- pulse_data, out, CNT_W+1: FIFO head. Bit CNT_W is the level of the completed pulse; bits CNT_W-1:0 are its width in ticks.
- ovf, out, 1: sticky flag, set when a completed pulse is dropped because the FIFO is full.

Behaviour:
- Reset:
  - All state is cleared asynchronously: s1, s2, filter count, prescaler, width counter, FIFO pointers/count.
  - Outputs after reset: tape_bit=0, pulse_valid=0, pulse_data=0, ovf=0.
- Synchroniser: two flops, tapein -> s1 -> s2.
- Filter:
  - fcnt counts clocks where s2 != tape_bit, and is cleared whenever s2 == tape_bit.
  - When s2 != tape_bit and fcnt == FILT_LEN-1, tape_bit toggles and fcnt is set to 0.
  - Latency: a tapein change that is stable before edge 1 appears on tape_bit at edge FILT_LEN+2.
  - Glitches shorter than FILT_LEN clocks (as seen at s2) never reach tape_bit.
- Prescaler:
  - pcnt counts 0..PRESC-1; tick is asserted when pcnt == PRESC-1, and pcnt then wraps to 0.
- Width counter:
  - Increments on each tick and saturates at 2^CNT_W-1; it does not wrap.
- On a tape_bit toggle (edge event):
  - Push {old tape_bit, width} into the FIFO.
  - Set width to 0 and pcnt to 0 in the same cycle.
  - Result: width = floor(pulse_length_in_clocks / PRESC).
  - Both edges see the same filter delay, so the measured length equals the input length.
- FIFO:
  - Synchronous, DEPTH entries, show-ahead: pulse_data is the head entry whenever pulse_valid=1.
  - pulse_data is don't-care while empty; it is 0 after reset.
  - Push while full and no pop in that cycle: the entry is dropped, ovf<=1, and contents are unchanged.
  - Push and pop in the same cycle while full: both are performed, count is unchanged, ovf is unaffected.
  - Pop while empty: ignored.
  - Push and pop in the same cycle while empty: the entry is stored, and pulse_valid rises next cycle.
  - A pushed entry is visible on pulse_data/pulse_valid one clock after the edge event.
- ovf: sticky; cleared only by clr or rst.
- clr:
  - Empties the FIFO, sets ovf<=0, width<=0, pcnt<=0.
  - Does not affect s1, s2, fcnt or tape_bit.
  - clr together with an edge event in the same cycle: clr wins, and nothing is pushed.
  - clr together with pop: pop is ignored.
- Reset asserted mid-pulse: the partial width is discarded, and the first pulse after reset is measured from the first tape_bit toggle after reset.

Test Plan (PRESC=28, FILT_LEN=4, CNT_W=16, DEPTH=4):
1. Reset: assert rst with tapein toggling -> tape_bit=0, pulse_valid=0, ovf=0 throughout.
2. Latency: tapein 0->1 before edge 1 and held -> tape_bit=1 exactly at edge 6, and an entry {0, width} is pushed at that edge.
3. Glitch rejection: tapein high for 3 clocks, then low -> tape_bit stays 0 and no push occurs; a 4-clock high pulse (at s2) -> tape_bit toggles.
4. Pulse measurement: clean high pulse of 280 clocks after a long low, then pop the low entry -> pulse_data = {1, 16'd10}. A 300-clock pulse also gives 10; 308 clocks gives 11.
5. Overflow: 5 completed pulses without pop -> pulse_valid=1, 4 entries retained in order, ovf=1. Popping 4 times -> pulse_valid=0, ovf still 1. clr -> ovf=0. Push and pop together when full -> ovf stays 0.
6. Saturation: tapein held low for 70000*28 clocks, then high -> pushed entry = {0, 16'hFFFF}. Then clr coincident with an edge event -> FIFO empty, nothing pushed.

Source files
------------

// File: rtl/tape_in.sv
// Tape-input receiver: synchronise and deglitch the EAR pin, time every completed pulse into a FIFO.
// Latency: pin change -> tape_bit after FILT_LEN+2 clocks; a pulse entry is visible one clock after its tape_bit toggle.
// Backpressure: none toward the pin; a pulse completing into a full FIFO (without a same-cycle pop) is dropped and sets ovf.
// Ports: clk/rst (async, active-high); tapein raw pin; pop consumes the FIFO head; clr flushes FIFO and ovf;
//        tape_bit filtered level; pulse_valid FIFO not empty; pulse_data head {level, width in ticks}; ovf sticky drop flag.
module tape_in #(
   parameter int PRESC    = 28,
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 16,
   parameter int DEPTH    = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tapein,
   input  logic           pop,
   input  logic           clr,
   output logic           tape_bit,
   output logic           pulse_valid,
   output logic [CNT_W:0] pulse_data,
   output logic           ovf
);

   localparam int FW = $clog2(FILT_LEN);
   localparam int PW = $clog2(PRESC);
   localparam int AW = $clog2(DEPTH);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
   localparam logic [AW:0]   DEPTH_CNT  = (AW + 1)'(DEPTH);

   // ------------------------------------------------------------------
   // Synchroniser and deglitch filter
   // ------------------------------------------------------------------
   logic          s1;
   logic          s2;
   logic [FW-1:0] fcnt;
   logic          edge_evt;

   // The accepted level flips on the FILT_LEN-th consecutive differing sample.
   assign edge_evt = (s2 != tape_bit) && (fcnt == FILT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         fcnt     <= '0;
         tape_bit <= 1'b0;
      end else begin
         s1 <= tapein;
         s2 <= s1;
         if (s2 == tape_bit) begin
            fcnt <= '0;
         end else if (edge_evt) begin
            fcnt     <= '0;
            tape_bit <= ~tape_bit;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Prescaler and pulse-width counter
   // ------------------------------------------------------------------
   logic [PW-1:0]    pcnt;
   logic             tick;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] width_nxt;

   assign tick = (pcnt == PRESC_LAST);

   // The pushed width includes a tick landing in the same cycle as the edge,
   // so a pulse of exactly N*PRESC clocks reports N.
   assign width_nxt = (tick && (width != '1)) ? width + CNT_W'(1) : width;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt  <= '0;
         width <= '0;
      end else if (clr || edge_evt) begin
         // Restart timing so the next pulse is measured from this edge.
         pcnt  <= '0;
         width <= '0;
      end else begin
         pcnt  <= tick ? '0 : pcnt + PW'(1);
         width <= width_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Show-ahead pulse FIFO
   // ------------------------------------------------------------------
   logic [CNT_W:0] mem [DEPTH];
   logic [AW-1:0]  rptr;
   logic [AW-1:0]  wptr;
   logic [AW:0]    count;
   logic           empty;
   logic           full;
   logic           do_pop;
   logic           do_push;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_CNT);
   assign do_pop  = pop && !clr && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = edge_evt && !clr && (!full || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (clr) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + (AW + 1)'(1);
         end else if (!do_push && do_pop) begin
            count <= count - (AW + 1)'(1);
         end
         if (edge_evt && !do_push) begin
            ovf <= 1'b1;
         end
      end
   end

   // Storage needs no reset: the read side is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= {tape_bit, width_nxt};
      end
   end

   assign pulse_valid = !empty;
   assign pulse_data  = empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_tape_in.sv
// Self-checking bench for tape_in: directed scenarios plus randomized pulse trains vs a queue-based reference.
// Latency: the reference predicts tape_bit FILT_LEN+1 clocks after the sampled pin and widths from edge-to-edge time.
// Backpressure: random pops/clears exercise FIFO fill, overflow and flush; a narrow-width twin checks saturation.
module tb_tape_in;
   localparam int PRESC    = 28;
   localparam int FILT_LEN = 4;
   localparam int CNT_W    = 16;
   localparam int DEPTH    = 4;
   localparam int NW       = 10;
   localparam int DLY      = FILT_LEN + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            tapein;
   logic            pop;
   logic            clr;
   logic            tape_bit;
   logic            pulse_valid;
   logic [CNT_W:0]  pulse_data;
   logic            ovf;
   logic            tape_bit_n;
   logic            pulse_valid_n;
   logic [NW:0]     pulse_data_n;
   logic            ovf_n;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: pin history (index 0 newest), expected level, pulse queue, overflow, timing.
   logic [DLY:0]   hist;
   logic           m_tb;
   logic           m_ovf;
   logic [CNT_W:0] m_q[$];
   int             cyc;
   int             ts;

   always #5 clk = ~clk;

   tape_in #(.PRESC(PRESC), .FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .tapein(tapein), .pop(pop), .clr(clr),
      .tape_bit(tape_bit), .pulse_valid(pulse_valid), .pulse_data(pulse_data), .ovf(ovf)
   );

   tape_in #(.PRESC(PRESC), .FILT_LEN(FILT_LEN), .CNT_W(NW), .DEPTH(DEPTH)) dut_n (
      .clk(clk), .rst(rst), .tapein(tapein), .pop(pop), .clr(clr),
      .tape_bit(tape_bit_n), .pulse_valid(pulse_valid_n), .pulse_data(pulse_data_n), .ovf(ovf_n)
   );

   // One clock of stimulus plus the reference update for that edge.
   task automatic step(input logic tin, input logic p, input logic c);
      logic           tog;
      logic [CNT_W:0] ent;
      int             w;
      tapein = tin;
      pop    = p;
      clr    = c;
      @(posedge clk);
      cyc++;
      hist = {hist[DLY-1:0], tin};
      tog  = (hist[DLY] != m_tb);
      w    = (cyc - ts) / PRESC;
      if (w > (2**CNT_W) - 1) w = (2**CNT_W) - 1;
      ent = {m_tb, w[CNT_W-1:0]};
      if (c) begin
         m_q.delete();
         m_ovf = 1'b0;
         ts    = cyc;
      end else begin
         if (p && m_q.size() > 0) void'(m_q.pop_front());
         if (tog) begin
            if (m_q.size() < DEPTH) m_q.push_back(ent);
            else m_ovf = 1'b1;
            ts = cyc;
         end
      end
      m_tb = hist[DLY];
      #1;
      pop = 1'b0;
      clr = 1'b0;
   endtask

   task automatic run(input logic lvl, input int n);
      repeat (n) step(lvl, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pop = 1'b0;
      clr = 1'b0;
      repeat (3) begin
         tapein = ~tapein;
         @(posedge clk);
         #1;
      end
      rst    = 1'b0;
      tapein = 1'b0;
      hist   = '0;
      m_tb   = 1'b0;
      m_ovf  = 1'b0;
      m_q.delete();
      cyc    = 0;
      ts     = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tapein = i[0];
         pop    = i[1];
         clr    = i[2];
         @(posedge clk);
         #1;
         n_checks++;
         if (tape_bit !== 1'b0) begin n_fail++; $display("FAIL reset_tape_bit: got %b expected 0", tape_bit); end
         n_checks++;
         if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pulse_valid); end
         n_checks++;
         if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
         n_checks++;
         if (pulse_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", pulse_data); end
      end
   endtask

   task automatic test_latency();
      logic exp_hi;
      do_reset();
      for (int e = 1; e <= FILT_LEN + 2; e++) begin
         step(1'b1, 1'b0, 1'b0);
         exp_hi = (e == FILT_LEN + 2);
         n_checks++;
         if (tape_bit !== exp_hi) begin n_fail++; $display("FAIL latency_tape_bit edge %0d: got %b expected %b", e, tape_bit, exp_hi); end
         n_checks++;
         if (pulse_valid !== exp_hi) begin n_fail++; $display("FAIL latency_valid edge %0d: got %b expected %b", e, pulse_valid, exp_hi); end
      end
      n_checks++;
      if (pulse_data !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL latency_entry: got %h expected %h", pulse_data, {1'b0, 16'd0}); end
   endtask

   task automatic test_glitch();
      int first_hi;
      do_reset();
      run(1'b0, 10);
      for (int i = 0; i < 15; i++) begin
         step(i < FILT_LEN - 1, 1'b0, 1'b0);
         n_checks++;
         if (tape_bit !== 1'b0) begin n_fail++; $display("FAIL glitch_short_level step %0d: got %b expected 0", i, tape_bit); end
         n_checks++;
         if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_short_push step %0d: got %b expected 0", i, pulse_valid); end
      end
      first_hi = -1;
      for (int i = 0; i < 15; i++) begin
         step(i < FILT_LEN, 1'b0, 1'b0);
         if (tape_bit === 1'b1 && first_hi < 0) first_hi = i;
      end
      n_checks++;
      if (first_hi != DLY) begin n_fail++; $display("FAIL glitch_min_pulse_toggle: got step %0d expected step %0d", first_hi, DLY); end
      n_checks++;
      if (pulse_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_min_pulse_push: got %b expected 1", pulse_valid); end
   endtask

   task automatic test_measure();
      int lens[3];
      int exps[3];
      lens = '{280, 300, 308};
      exps = '{10, 10, 11};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         run(1'b0, 40);
         run(1'b1, lens[k]);
         run(1'b0, 40);
         n_checks++;
         if (pulse_valid !== 1'b1) begin n_fail++; $display("FAIL measure_valid len %0d: got %b expected 1", lens[k], pulse_valid); end
         step(1'b0, 1'b1, 1'b0);
         n_checks++;
         if (pulse_data !== {1'b1, 16'(exps[k])}) begin
            n_fail++;
            $display("FAIL measure_width len %0d: got %h expected %h", lens[k], pulse_data, {1'b1, 16'(exps[k])});
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      run(1'b0, 30); run(1'b1, 40); run(1'b0, 50); run(1'b1, 60); run(1'b0, 70); run(1'b1, 30);
      n_checks++;
      if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (pulse_valid !== 1'b1 || pulse_data !== m_q[0]) begin
            n_fail++;
            $display("FAIL ovf_order entry %0d: got v=%b d=%h expected v=1 d=%h", i, pulse_valid, pulse_data, m_q[0]);
         end
         step(1'b1, 1'b1, 1'b0);
      end
      n_checks++;
      if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", pulse_valid); end
      n_checks++;
      if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
      step(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
      run(1'b0, 40); run(1'b1, 40); run(1'b0, 40); run(1'b1, 40);
      for (int i = 0; i < 20 && hist[DLY-1] == m_tb; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_ovf: got %b expected 0", ovf); end
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (pulse_valid !== 1'b1 || pulse_data !== m_q[0]) begin
            n_fail++;
            $display("FAIL full_push_pop_entry %0d: got v=%b d=%h expected v=1 d=%h", i, pulse_valid, pulse_data, m_q[0]);
         end
         step(1'b0, 1'b1, 1'b0);
      end
      n_checks++;
      if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_count: got %b expected 0", pulse_valid); end
   endtask

   task automatic test_saturation();
      logic [NW:0] exp_n;
      exp_n = {1'b0, {NW{1'b1}}};
      do_reset();
      run(1'b0, 1100 * PRESC);
      run(1'b1, 10);
      n_checks++;
      if (pulse_valid_n !== 1'b1 || pulse_data_n !== exp_n) begin
         n_fail++;
         $display("FAIL sat_narrow: got v=%b d=%h expected v=1 d=%h", pulse_valid_n, pulse_data_n, exp_n);
      end
      n_checks++;
      if (pulse_data !== {1'b0, 16'd1100}) begin n_fail++; $display("FAIL sat_wide_width: got %h expected %h", pulse_data, {1'b0, 16'd1100}); end
      for (int i = 0; i < 20 && hist[DLY-1] == m_tb; i++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (pulse_valid !== 1'b0 || pulse_valid_n !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_edge_flush: got v=%b v_n=%b expected 0 0", pulse_valid, pulse_valid_n);
      end
      n_checks++;
      if (tape_bit !== 1'b0 || tape_bit_n !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_edge_level: got %b %b expected 0 0", tape_bit, tape_bit_n);
      end
      n_checks++;
      if (ovf !== 1'b0 || ovf_n !== 1'b0) begin n_fail++; $display("FAIL clr_edge_ovf: got %b %b expected 0 0", ovf, ovf_n); end
      run(1'b0, 5);
      n_checks++;
      if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL clr_edge_no_push: got %b expected 0", pulse_valid); end
   endtask

   task automatic test_random();
      logic lvl;
      int   len;
      logic p;
      logic c;
      do_reset();
      lvl = 1'b0;
      for (int seg = 0; seg < 40; seg++) begin
         lvl = ~lvl;
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(FILT_LEN, 30) : $urandom_range(28, 400);
         for (int i = 0; i < len; i++) begin
            p = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 149) == 0);
            step(lvl, p, c);
            n_checks++;
            if (tape_bit !== m_tb) begin n_fail++; $display("FAIL rand_level cyc %0d: got %b expected %b", cyc, tape_bit, m_tb); end
            n_checks++;
            if (pulse_valid !== (m_q.size() > 0)) begin
               n_fail++;
               $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, pulse_valid, m_q.size() > 0);
            end
            n_checks++;
            if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc %0d: got %b expected %b", cyc, ovf, m_ovf); end
            if (m_q.size() > 0) begin
               n_checks++;
               if (pulse_data !== m_q[0]) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, pulse_data, m_q[0]); end
            end
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      tapein = 1'b0;
      pop    = 1'b0;
      clr    = 1'b0;
      hist   = '0;
      m_tb   = 1'b0;
      m_ovf  = 1'b0;
      cyc    = 0;
      ts     = 0;
      test_reset();
      test_latency();
      test_glitch();
      test_measure();
      test_overflow();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
